// File: rtl/sha_msg_loader.sv
// SHA-256 message loader: packs bytes big-endian into the 16x32 block memory.
// Define SHA_MSG_PAD_EN for FIPS 180-4 padding; otherwise in_last zero-fills.
module sha_msg_loader #(
    parameter int W = 32,
    parameter int L = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 wr_en,
    output logic [$clog2(L)-1:0] wr_addr,
    output logic [W-1:0]         wr_data,
    output logic                 blk_valid,
    output logic                 blk_last,
    input  logic                 blk_ack
);
    localparam int AW = $clog2(L);

    typedef enum logic [2:0] {
        ACCEPT, PAD80, PADZ, LEN, HOLD
    } state_t;

    state_t         r_state;
    state_t         r_ret;
    state_t         w_next;
    state_t         w_ret;
    logic [5:0]     r_idx;
    logic [23:0]    r_sh;
    logic           r_ready;
    logic           r_blk_valid;
    logic           r_last;
    logic           r_wr_en;
    logic [AW-1:0]  r_wr_addr;
    logic [W-1:0]   r_wr_data;
    logic           w_acc;
    logic           w_ben;
    logic           w_setlast;
    logic           w_ack;
    logic           w_idx63;
    logic [7:0]     w_byte;

`ifdef SHA_MSG_PAD_EN
    logic [60:0]    r_cnt;
    logic [63:0]    w_len_sh;
    logic           w_idx55;
    // Length bytes go out MSB first: shift the bit count left by 8*k.
    assign w_len_sh = {r_cnt, 3'b000} << {r_idx[2:0], 3'b000};
    assign w_idx55  = (r_idx == 6'd55);
`endif

    assign w_acc    = in_valid && r_ready;
    assign w_idx63  = (r_idx == 6'd63);
    assign w_ack    = r_blk_valid && blk_ack && (r_state == HOLD);

    assign in_ready  = r_ready;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign blk_valid = r_blk_valid;
    assign blk_last  = r_last;

    always_comb begin
        w_next    = r_state;
        w_ret     = r_ret;
        w_ben     = 1'b0;
        w_byte    = 8'h00;
        w_setlast = 1'b0;
        unique case (r_state)
            ACCEPT: begin
                if (w_acc) begin
                    w_ben  = 1'b1;
                    w_byte = in_data;
`ifdef SHA_MSG_PAD_EN
                    if (w_idx63) begin
                        w_next = HOLD;
                        w_ret  = in_last ? PAD80 : ACCEPT;
                    end else if (in_last) begin
                        w_next = PAD80;
                    end
`else
                    if (w_idx63) begin
                        w_next    = HOLD;
                        w_ret     = ACCEPT;
                        w_setlast = in_last;
                    end else if (in_last) begin
                        w_next = PADZ;
                    end
`endif
                end
            end
`ifdef SHA_MSG_PAD_EN
            PAD80: begin
                w_ben  = 1'b1;
                w_byte = 8'h80;
                if (w_idx63) begin
                    w_next = HOLD;
                    w_ret  = PADZ;
                end else if (w_idx55) begin
                    w_next = LEN;
                end else begin
                    w_next = PADZ;
                end
            end
            PADZ: begin
                w_ben = 1'b1;
                if (w_idx55) begin
                    w_next = LEN;
                end else if (w_idx63) begin
                    w_next = HOLD;
                    w_ret  = PADZ;
                end
            end
            LEN: begin
                w_ben  = 1'b1;
                w_byte = w_len_sh[63:56];
                if (w_idx63) begin
                    w_next    = HOLD;
                    w_ret     = ACCEPT;
                    w_setlast = 1'b1;
                end
            end
`else
            PADZ: begin
                w_ben = 1'b1;
                if (w_idx63) begin
                    w_next    = HOLD;
                    w_ret     = ACCEPT;
                    w_setlast = 1'b1;
                end
            end
`endif
            HOLD: begin
                if (w_ack) w_next = r_ret;
            end
            default: w_next = ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ACCEPT;
            r_ret       <= ACCEPT;
            r_idx       <= 6'd0;
            r_sh        <= 24'd0;
            r_ready     <= 1'b0;
            r_blk_valid <= 1'b0;
            r_last      <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
`ifdef SHA_MSG_PAD_EN
            r_cnt       <= 61'd0;
`endif
        end else begin
            r_state <= w_next;
            r_ret   <= w_ret;
            r_ready <= (w_next == ACCEPT);
            r_wr_en <= 1'b0;
            if (w_ben) begin
                r_idx <= r_idx + 6'd1;
                r_sh  <= {r_sh[15:0], w_byte};
                if (r_idx[1:0] == 2'b11) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= AW'(r_idx[5:2]);
                    r_wr_data <= W'({r_sh, w_byte});
                end
            end else if (w_ack) begin
                r_idx <= 6'd0;
            end
            // Valid only once the word 15 write has landed in memory.
            if (r_wr_en && (r_wr_addr == AW'(L - 1)))
                r_blk_valid <= 1'b1;
            else if (w_ack)
                r_blk_valid <= 1'b0;
            if (w_setlast)
                r_last <= 1'b1;
            else if (w_ack)
                r_last <= 1'b0;
`ifdef SHA_MSG_PAD_EN
            if (w_ack && r_last)
                r_cnt <= 61'd0;
            else if (w_acc)
                r_cnt <= r_cnt + 61'd1;
`endif
        end
    end
endmodule

// File: tb/tb_sha_msg_loader.sv
// Directed self-checking bench for sha_msg_loader.
// Covers both SHA_MSG_PAD_EN builds with hand-computed block contents.
module tb_sha_msg_loader;
`ifdef SHA_MSG_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        blk_ack = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        blk_valid;
    logic        blk_last;

    int          checks = 0;
    int          errors = 0;
    int          nwr = 0;
    logic        clr = 1'b0;
    logic [31:0] mem [16];

    sha_msg_loader #(.W(32), .L(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .blk_valid(blk_valid),
        .blk_last(blk_last), .blk_ack(blk_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clr) begin
            nwr <= 0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'hDEADBEEF;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
            nwr <= nwr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr_mem();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_blk(input string tag);
        int n;
        n = 0;
        while (blk_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, blk_valid}, 32'd1);
    endtask

    task automatic ack();
        @(negedge clk);
        blk_ack = 1'b1;
        @(posedge clk);
        #1;
        blk_ack = 1'b0;
        @(negedge clk);
        chk("ack_valid_fall", {31'd0, blk_valid}, 32'd0);
        chk("ack_ready_back", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic chk_zero(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            chk($sformatf("zero_w%0d", i), mem[i], 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        chk({tag, "_wr_addr"}, {28'd0, wr_addr}, 32'd0);
        chk({tag, "_wr_data"}, wr_data, 32'd0);
        chk({tag, "_blk_valid"}, {31'd0, blk_valid}, 32'd0);
        chk({tag, "_blk_last"}, {31'd0, blk_last}, 32'd0);
    endtask

    task automatic run_abc(input string tag);
        clr_mem();
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b1);
        @(negedge clk);
        chk({tag, "_rdy_drop"}, {31'd0, in_ready}, 32'd0);
        wait_blk({tag, "_blk"});
        chk({tag, "_w0"}, mem[0], PAD ? 32'h61626380 : 32'h61626300);
        chk_zero(1, 14);
        chk({tag, "_w15"}, mem[15], PAD ? 32'h00000018 : 32'h0);
        chk({tag, "_last"}, {31'd0, blk_last}, 32'd1);
        chk({tag, "_nwr"}, nwr, 32'd16);
        ack();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_rise", {31'd0, in_ready}, 32'd1);

        run_abc("abc");

`ifdef SHA_MSG_PAD_EN
        clr_mem();
        for (int i = 0; i < 55; i++) send(8'h00, i == 54);
        wait_blk("z55_blk");
        chk_zero(0, 12);
        chk("z55_w13", mem[13], 32'h00000080);
        chk("z55_w14", mem[14], 32'h0);
        chk("z55_w15", mem[15], 32'h000001B8);
        chk("z55_last", {31'd0, blk_last}, 32'd1);
        ack();

        clr_mem();
        for (int i = 0; i < 56; i++) send(8'h00, i == 55);
        wait_blk("z56_blk0");
        chk("z56_w14", mem[14], 32'h80000000);
        chk("z56_w15", mem[15], 32'h0);
        chk("z56_last0", {31'd0, blk_last}, 32'd0);
        @(negedge clk);
        blk_ack = 1'b1;
        @(posedge clk);
        #1;
        blk_ack = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        wait_blk("z56_blk1");
        chk_zero(0, 14);
        chk("z56_w15b", mem[15], 32'h000001C0);
        chk("z56_last1", {31'd0, blk_last}, 32'd1);
        chk("z56_nwr1", nwr, 32'd16);
        ack();
`else
        clr_mem();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        send(8'h55, 1'b1);
        wait_blk("b5_blk");
        chk("b5_w0", mem[0], 32'h11223344);
        chk("b5_w1", mem[1], 32'h55000000);
        chk_zero(2, 15);
        chk("b5_last", {31'd0, blk_last}, 32'd1);
        chk("b5_nwr", nwr, 32'd16);
        ack();

        clr_mem();
        for (int i = 0; i < 64; i++) send(8'hC3, i == 63);
        wait_blk("f64_blk");
        chk("f64_w15", mem[15], 32'hC3C3C3C3);
        chk("f64_last", {31'd0, blk_last}, 32'd1);
        chk("f64_nwr", nwr, 32'd16);
        ack();
`endif

        clr_mem();
        for (int i = 0; i < 64; i++) send(8'(i), 1'b0);
        wait_blk("bp_blk0");
        chk("bp_w0", mem[0], 32'h00010203);
        chk("bp_w7", mem[7], 32'h1C1D1E1F);
        chk("bp_w15", mem[15], 32'h3C3D3E3F);
        chk("bp_last0", {31'd0, blk_last}, 32'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_valid", {31'd0, blk_valid}, 32'd1);
        end
        chk("bp_nwr", nwr, 32'd16);
        ack();
        clr_mem();
        for (int i = 64; i < 70; i++) send(8'(i), i == 69);
        wait_blk("bp_blk1");
        chk("bp_b1w0", mem[0], 32'h40414243);
        chk("bp_b1w1", mem[1], PAD ? 32'h44458000 : 32'h44450000);
        chk_zero(2, 14);
        chk("bp_b1w15", mem[15], PAD ? 32'h00000230 : 32'h0);
        chk("bp_last1", {31'd0, blk_last}, 32'd1);
        ack();

        clr_mem();
        for (int i = 0; i < 22; i++) send(8'hA5, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("mid");
        chk("mid_nwr", nwr, 32'd5);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_nwr_hold", nwr, 32'd5);
        run_abc("abc2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sha_msg_loader.md
# sha_msg_loader

Byte-stream writer that fills the 16 × 32-bit message-block memory consumed by the SHA-256 compression core. Accepts message bytes over a valid/ready handshake and packs them big-endian into words. Issues one synchronous write per completed word and applies FIPS 180-4 padding after the last byte. Hands each finished 512-bit block to the compressor with a valid/ack pair.

## Interface
Parameters:
- `W`, 32: word width in bits; fixed at 32 for SHA-256.
- `L`, 16: words per block; the address width is `$clog2(L)`.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: synchronous reset, active-low.
- `in_data`, in, 8: message byte.
- `in_valid`, in, 1: `in_data` is valid.
- `in_last`, in, 1: qualifies the byte as the final message byte.
- `in_ready`, out, 1: the loader can accept a byte.
- `wr_en`, out, 1: one-cycle write strobe to the block memory.
- `wr_addr`, out, `$clog2(L)`: word index 0–15.
- `wr_data`, out, `W`: packed word, with the first byte in [31:24].
- `blk_valid`, out, 1: a full block is resident in memory.
- `blk_last`, out, 1: the block is the final (padded) block; meaningful only while `blk_valid` is high.
- `blk_ack`, in, 1: the consumer has finished reading the block.

## Operation
- **States**
  - `ACCEPT`: take input bytes.
  - `PAD80`: inject 0x80.
  - `PADZ`: inject 0x00.
  - `LEN`: inject 8 length bytes, MSB first.
  - `HOLD`: block handed off, wait for ack.
- **Common byte path**
  - Input bytes and injected pad bytes use the same packer, one byte per cycle.
  - A 6-bit byte index (0–63) tracks the position within the block.
  - A 61-bit message byte counter tracks the total; the bit length is `{count, 3'b000}`, 64 bits.
- **`ACCEPT`**
  - A byte is accepted when `in_valid && in_ready`.
  - `in_last` on the accepted byte moves the FSM to `PAD80`.
- **`PAD80`**: injects one 0x80 byte, then goes to `PADZ`.
- **`PADZ`**
  - Injects 0x00 until the byte index reaches 56, then goes to `LEN`.
  - If the index is past 56, it zero-fills to 63, the block is emitted via `HOLD`, and zero filling continues in the new block up to index 56.
- **`LEN`**
  - Injects 8 bytes.
  - The block completes with `blk_last = 1`.
- **Block completion**
  - Byte index 63 packed → the word 15 write → `HOLD`.
  - In `HOLD`, `blk_valid` stays high until `blk_ack` is sampled high.
  - On ack, the byte index is cleared. The FSM returns to `ACCEPT` after a normal block, or to the pad state it left after a padding block.
  - After a `blk_last` block, the FSM returns to `ACCEPT` and clears the byte counter.
- **Input rules**
  - `in_ready` is high only in `ACCEPT`.
  - `blk_ack` is ignored when `blk_valid` is low.
  - Zero-length messages are not supported; `in_last` always accompanies a data byte.

## Timing
- Reset values: `in_ready = 0`, `wr_en = 0`, `wr_addr = 0`, `wr_data = 0`, `blk_valid = 0`, `blk_last = 0`. `in_ready` rises in the first cycle after `rst_n` goes high.
- `wr_en`, `wr_addr` and `wr_data` are registered. They are asserted in the cycle after the 4th byte of a word is accepted or injected.
- `blk_valid` rises the cycle after the word 15 write, so the memory is settled. It falls the cycle after `blk_ack` is sampled.
- Throughput:
  - 1 byte per cycle in `ACCEPT` and the pad states.
  - 0 bytes per cycle in `HOLD`.
  - At least 1 ack cycle per block.
- `in_ready` drops in the cycle after a block's 64th byte is accepted, and after an `in_last` byte.
- `in_valid` without `in_ready` has no effect; `in_data` may change freely.
- Reset mid-block or mid-padding:
  - All state returns to the reset values next cycle.
  - Partial words are discarded; no `wr_en` is issued.
  - The byte counter is cleared.

## Configuration
- `SHA_MSG_PAD_EN` defined:
  - Full padding engine: the `PAD80`, `PADZ` and `LEN` states and the 61-bit counter.
- `SHA_MSG_PAD_EN` undefined:
  - No padding states and no counter.
  - `in_last` zero-fills the remainder of the current block (0 if already at byte 63).
  - That block is emitted with `blk_last = 1`.
  - Blocks otherwise emit every 64 bytes.

## Test plan
- **"abc"**: 0x61, 0x62, 0x63 with `in_last` on 0x63 → writes word 0 = 0x61626380, words 1–14 = 0, word 15 = 0x00000018; `blk_valid` and `blk_last` = 1.
- **55 bytes of 0x00**: word 13 = 0x00000080 and word 15 = 0x000001B8 in a single block with `blk_last = 1`.
- **56 bytes of 0x00**:
  - Block 0 has word 14 = 0x80000000, word 15 = 0, `blk_last = 0`.
  - After ack, block 1 has words 0–14 = 0, word 15 = 0x000001C0, `blk_last = 1`.
- **Backpressure**: 70 bytes with `blk_ack` held low for 10 cycles after the first `blk_valid` → `in_ready` stays low, no `wr_en` occurs, and `blk_valid` stays high. After ack, bytes resume at word 0.
- **Mid-block reset**: `rst_n` low for 1 cycle after 22 bytes → all outputs at their reset values. Then sending "abc" reproduces the first scenario exactly.
- **Macro off**: 5 bytes with `in_last` → word 0 = bytes 0–3, word 1 = byte 4 followed by 0x000000, words 2–15 = 0, `blk_last = 1`.
